tdm_demux_2ch: RTL

TDM_DEMUX_2CH -- requirements
Module: tdm_demux_2ch

---
 rtl/tdm_demux_2ch.sv | 114 +++++++++++
 1 files changed

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM serial demultiplexer.
// A frame is WIDTH bits of channel 0 followed by WIDTH bits of channel 1,
// both MSB first, with one bit consumed per bit_en strobe. sync marks the
// first channel-0 bit. Completed words are registered, and each update
// raises a one-cycle valid pulse. A sync that arrives mid-frame drops the
// partial word, raises frame_err and restarts the frame.
module tdm_demux_2ch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch0_valid,
  output logic             ch1_valid,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] ch0_q;
  logic [WIDTH-1:0] ch1_q;
  logic             ch0_valid_q;
  logic             ch1_valid_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] first_d;
  logic             last_bit;

  // Next shift contents, the first-bit load value and the slot-end flag.
  // cnt_q holds the number of bits already received in the current slot.
  always_comb begin
    shift_d  = {shift_q[WIDTH-2:0], din};
    first_d  = WIDTH'(din);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Frame FSM: slot tracking, word capture and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ch0_q       <= '0;
      ch1_q       <= '0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (bit_en) begin
        unique case (state_q)
          IDLE: begin
            if (sync) begin
              shift_q <= first_d;
              cnt_q   <= CW'(1);
              state_q <= CH0;
            end
          end
          CH0, CH1: begin
            if (sync) begin
              // A sync here is the first bit of a new frame; the partial word is lost.
              frame_err_q <= 1'b1;
              shift_q     <= first_d;
              cnt_q       <= CW'(1);
              state_q     <= CH0;
            end else if (last_bit) begin
              shift_q <= shift_d;
              cnt_q   <= '0;
              if (state_q == CH0) begin
                ch0_q       <= shift_d;
                ch0_valid_q <= 1'b1;
                state_q     <= CH1;
              end else begin
                ch1_q       <= shift_d;
                ch1_valid_q <= 1'b1;
                state_q     <= IDLE;
              end
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ch0_data  = ch0_q;
  assign ch1_data  = ch1_q;
  assign ch0_valid = ch0_valid_q;
  assign ch1_valid = ch1_valid_q;
  assign frame_err = frame_err_q;

endmodule
